// File: rtl/uart_rx_core.sv
// Serial receive engine: synchronizes rx and oversamples it on baud_pulse.
// It deframes start/data/parity/stop and pushes each character with its pe/fe/bi flags.
// Optional UART_RX_MAJORITY_VOTE_EN: each bit is a 2-of-3 vote over ticks 6/7/8.
module uart_rx_core #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  output logic [7:0] dout,
  output logic       push,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] DEC  = MID + 4'd1;
`else
  localparam logic [3:0] DEC  = MID;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [1:0]             wls_q, wls_d;
  logic                   pen_q, pen_d, eps_q, eps_d, stk_q, stk_d;
  logic [7:0]             dout_q, dout_d;
  logic                   push_q, push_d, pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
  logic                   rxs, bit_val, exp_par, tick_dec, tick_last;
  logic [3:0]             cnt_inc;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic                   s6_q, s6_d, s7_q, s7_d;
`endif

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  assign bit_val = (s6_q & s7_q) | (s6_q & rxs) | (s7_q & rxs);
`else
  assign bit_val = rxs;
`endif

  assign tick_dec  = baud_pulse && (cnt_q == DEC);
  assign tick_last = baud_pulse && (cnt_q == LAST);
  assign cnt_inc   = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
  assign exp_par   = stk_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], rx};
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    wls_d    = wls_q;
    pen_d    = pen_q;
    eps_d    = eps_q;
    stk_d    = stk_q;
    dout_d   = dout_q;
    push_d   = 1'b0;
    pe_d     = pe_q;
    fe_d     = fe_q;
    bi_d     = bi_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    s6_d = s6_q;
    s7_d = s7_q;
    if (baud_pulse && cnt_q == MID - 4'd1) s6_d = rxs;
    if (baud_pulse && cnt_q == MID)        s7_d = rxs;
`endif
    if (baud_pulse && state_q != IDLE) cnt_d = cnt_inc;

    case (state_q)
      IDLE: begin
        if (baud_pulse && !rxs) begin
          state_d  = START;
          cnt_d    = 4'd0;
          bitcnt_d = 3'd0;
          shift_d  = 8'd0;
          par_d    = 1'b0;
          wls_d    = wls;
          pen_d    = pen;
          eps_d    = eps;
          stk_d    = sticky_parity;
        end
      end
      START: begin
        // Glitch check at mid-start; the counter then runs out the start bit
        // so every later bit is sampled at the same mid-bit tick.
        if (tick_dec && bit_val) state_d = IDLE;
        else if (tick_last)      state_d = DATA;
      end
      DATA: begin
        if (tick_dec) shift_d[bitcnt_q] = bit_val;
        if (tick_last) begin
          if (bitcnt_q == 3'(wls_q) + 3'd4) begin
            bitcnt_d = 3'd0;
            state_d  = pen_q ? PARITY : STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick_dec)  par_d   = bit_val;
        if (tick_last) state_d = STOP;
      end
      STOP: begin
        if (tick_dec) begin
          push_d  = 1'b1;
          dout_d  = shift_q;
          fe_d    = ~bit_val;
          pe_d    = pen_q & (par_q != exp_par);
          bi_d    = (shift_q == 8'd0) & (~pen_q | ~par_q) & ~bit_val;
          state_d = bit_val ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line yields one push; re-arm only once it goes idle.
        if (baud_pulse && rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '1;
      cnt_q    <= 4'd0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'd0;
      par_q    <= 1'b0;
      wls_q    <= 2'd0;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      stk_q    <= 1'b0;
      dout_q   <= 8'd0;
      push_q   <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      bi_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      s6_q     <= 1'b1;
      s7_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      wls_q    <= wls_d;
      pen_q    <= pen_d;
      eps_q    <= eps_d;
      stk_q    <= stk_d;
      dout_q   <= dout_d;
      push_q   <= push_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      bi_q     <= bi_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      s6_q     <= s6_d;
      s7_q     <= s7_d;
`endif
    end
  end

  assign dout = dout_q;
  assign push = push_q;
  assign pe   = pe_q;
  assign fe   = fe_q;
  assign bi   = bi_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: frames are built bit by bit and checked
// against a character-level model of the receiver's rules.
module tb_uart_rx_core;
  logic       clk = 1'b0, rst = 1'b1, baud_pulse = 1'b0, rx = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0, eps = 1'b0, sticky_parity = 1'b0;
  logic [7:0] dout;
  logic       push, pe, fe, bi, busy;

  int checks = 0;
  int errors = 0;
  logic [10:0] evq[$];   // {bi, fe, pe, dout} per observed push

  uart_rx_core dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx), .wls(wls),
    .pen(pen), .eps(eps), .sticky_parity(sticky_parity), .dout(dout),
    .push(push), .pe(pe), .fe(fe), .bi(bi), .busy(busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, so one bit period is 64 clocks.
  initial forever begin
    repeat (3) @(posedge clk);
    #1 baud_pulse = 1'b1;
    @(posedge clk);
    #1 baud_pulse = 1'b0;
  end

  always @(negedge clk) if (push) evq.push_back({bi, fe, pe, dout});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(64);
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
    wls = w; pen = p; eps = e; sticky_parity = s;
  endtask

  // Drives a whole frame; config inputs are scrambled after the start bit
  // since the receiver must use the settings latched at frame start.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                            input logic par, input logic stop);
    send_bit(1'b0);
    set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 5 + int'(w); i++) send_bit(d[i]);
    if (p) send_bit(par);
    send_bit(stop);
    rx = 1'b1;
    wait_clk(64);
  endtask

  // Character-level expectation: {bi, fe, pe, dout}.
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] w,
      input logic p, input logic e, input logic s, input logic par, input logic stop);
    int   nb = 5 + int'(w);
    logic [7:0] dm = d & 8'((1 << nb) - 1);
    logic ones_odd = ^dm;
    logic want = s ? ~e : (e ? ones_odd : ~ones_odd);
    logic xpe = p && (par != want);
    logic xbi = (dm == 8'd0) && (!p || !par) && !stop;
    return {xbi, !stop, xpe, dm};
  endfunction

  task automatic expect_one(input string tag, input logic [10:0] exp);
    logic [10:0] ev;
    chk({tag, ".pushes"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk({tag, ".dout"}, ev[7:0], exp[7:0]);
      chk({tag, ".pe"},   ev[8],   exp[8]);
      chk({tag, ".fe"},   ev[9],   exp[9]);
      chk({tag, ".bi"},   ev[10],  exp[10]);
    end
    evq.delete();
    chk({tag, ".busy"}, busy, 0);
  endtask

  task automatic frame_test(input string tag, input logic [7:0] d, input logic [1:0] w,
      input logic p, input logic e, input logic s, input logic par, input logic stop);
    set_cfg(w, p, e, s);
    send_frame(d, w, p, par, stop);
    expect_one(tag, model(d, w, p, e, s, par, stop));
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] w;
    logic       p, e, s, par, stop;

    wait_clk(4);
    chk("rst_busy_in_reset", busy, 0);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_push", push, 0);
    chk("rst_dout", dout, 0);
    chk("rst_flags", {pe, fe, bi}, 0);
    chk("rst_busy", busy, 0);
    wait_clk(128);

    frame_test("8n1_a5",    8'hA5, 2'b11, 0, 0, 0, 0, 1);
    frame_test("7e1_35_p0", 8'h35, 2'b10, 1, 1, 0, 0, 1);
    frame_test("7e1_35_p1", 8'h35, 2'b10, 1, 1, 0, 1, 1);
    frame_test("5b_stick",  8'h1F, 2'b00, 1, 0, 1, 1, 1);
    frame_test("8n1_fe_3c", 8'h3C, 2'b11, 0, 0, 0, 0, 0);

    // Line held low for two frame times: exactly one break push.
    set_cfg(2'b11, 0, 0, 0);
    rx = 1'b0;
    wait_clk(64 * 20);
    chk("brk_busy_held", busy, 1);
    rx = 1'b1;
    wait_clk(128);
    expect_one("brk", {1'b1, 1'b1, 1'b0, 8'h00});
    frame_test("after_brk", 8'h5A, 2'b11, 0, 0, 0, 0, 1);

    // Short low pulse on an idle line is rejected as a glitch.
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(128);
    chk("glitch_pushes", evq.size(), 0);
    chk("glitch_busy", busy, 0);
    evq.delete();

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-tick dropout in the middle of data bit 3 is outvoted.
    set_cfg(2'b11, 0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx = 1'b1; wait_clk(32);
        rx = 1'b0; wait_clk(4);
        rx = 1'b1; wait_clk(28);
      end else send_bit(1'b1);
    end
    send_bit(1'b1);
    wait_clk(64);
    expect_one("vote_ff", {1'b0, 1'b0, 1'b0, 8'hFF});
`endif

    // Reset in the middle of data bit 4 discards the character.
    set_cfg(2'b11, 0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_clk(20);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_out", {push, pe, fe, bi, dout}, 0);
    wait_clk(128);
    chk("mrst_pushes", evq.size(), 0);
    evq.delete();
    frame_test("mrst_81", 8'h81, 2'b11, 0, 0, 0, 0, 1);

    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      w    = 2'($urandom);
      p    = 1'($urandom);
      e    = 1'($urandom);
      s    = ($urandom_range(0, 3) == 0);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      frame_test($sformatf("rnd%0d", n), d, w, p, e, s, par, stop);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
